// File: rtl/text_pkg.sv
// Shared constants and types for the text-mode pixel renderer.
//   Geometry:  H_ACTIVE x V_ACTIVE visible area, CHAR_W x CHAR_H glyph cell,
//              COLS x ROWS text grid (lines 592..599 sit below the grid).
//   PIPE_LAT:  fixed counter-to-pixel latency of the renderer.
//   PALETTE:   16-entry VGA colour set, 12-bit {R4,G4,B4}.
package text_pkg;

   localparam int H_ACTIVE = 800;
   localparam int V_ACTIVE = 600;
   localparam int CHAR_W   = 8;
   localparam int CHAR_H   = 16;
   localparam int COLS     = 100;
   localparam int ROWS     = 37;
   localparam int PIPE_LAT = 5;
   localparam int TEXT_AW  = 12;
   localparam int FONT_AW  = 12;

   // Text RAM word layout: [15:12] bg, [11:8] fg, [7:0] character code.
   typedef struct packed {
      logic [3:0] bg;
      logic [3:0] fg;
      logic [7:0] chr;
   } text_attr_t;

   // Per-slot sideband that rides alongside the RAM/ROM reads.
   typedef struct packed {
      logic       active;
      logic       in_text;
      logic [2:0] dot;
      logic [3:0] gline;
      logic       cur_hit;
   } side_t;

   localparam logic [11:0] PALETTE [16] = '{
      12'h000, 12'h00A, 12'h0A0, 12'h0AA,
      12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
      12'h555, 12'h55F, 12'h5F5, 12'h5FF,
      12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
   };

endpackage

// File: rtl/text_blink_timer.sv
// Cursor blink timer, only instantiated when CURSOR_BLINK_EN is defined.
// Detects the last visible dot of a frame, counts BLINK_FR frames and
// toggles blink_phase each time the count wraps.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   active              counter-advance qualifier
//   dot_counter         current x position
//   scanline_counter    current y position
//   blink_phase         cursor visible when 1; starts at 0 after reset
module text_blink_timer
   import text_pkg::*;
#(
   parameter int BLINK_FR = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       active,
   input  logic [9:0] dot_counter,
   input  logic [9:0] scanline_counter,
   output logic       blink_phase
);

   localparam int CW = $clog2(BLINK_FR > 1 ? BLINK_FR : 2);
   localparam logic [CW-1:0] LOAD = CW'(BLINK_FR - 1);

   logic          frame_end;
   logic [CW-1:0] frame_cnt;

   assign frame_end = active
                    && (dot_counter == 10'(H_ACTIVE - 1))
                    && (scanline_counter == 10'(V_ACTIVE - 1));

   // Down-counter: reaching zero on a frame end marks BLINK_FR elapsed frames.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt   <= LOAD;
         blink_phase <= 1'b0;
      end else if (frame_end) begin
         if (frame_cnt == '0) begin
            frame_cnt   <= LOAD;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt <= frame_cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/text_pixel_renderer.sv
// Text-mode pixel renderer: turns each dot/scanline position into a 12-bit
// RGB pixel with a fixed 5-cycle latency and no stalls.
//   t+1 text_addr/text_rd_en, t+2 text_data, t+3 font_addr/font_rd_en,
//   t+4 font_data, t+5 pixel_rgb/pixel_valid.
// Optional feature macro: CURSOR_BLINK_EN (blinking underline cursor on
// glyph lines 14..15 of the cursor cell). Without it the cursor ports are
// accepted but ignored.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   active                         counter-advance qualifier
//   dot_counter, scanline_counter  current x / y position
//   cursor_col, cursor_row         cursor cell
//   text_rd_en, text_addr          text RAM read (row*COLS+col)
//   text_data                      {bg, fg, char}, valid 1 cycle after read
//   font_rd_en, font_addr          font ROM read ({char, glyph_line})
//   font_data                      glyph row, bit 7 = leftmost dot
//   pixel_rgb, pixel_valid         output pixel stream
module text_pixel_renderer
   import text_pkg::*;
#(
   parameter int BLINK_FR = 30
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               active,
   input  logic [9:0]         dot_counter,
   input  logic [9:0]         scanline_counter,
   input  logic [6:0]         cursor_col,
   input  logic [5:0]         cursor_row,
   output logic               text_rd_en,
   output logic [TEXT_AW-1:0] text_addr,
   input  logic [15:0]        text_data,
   output logic               font_rd_en,
   output logic [FONT_AW-1:0] font_addr,
   input  logic [7:0]         font_data,
   output logic [11:0]        pixel_rgb,
   output logic               pixel_valid
);

   logic [6:0]  col;
   logic [5:0]  row;
   logic        in_text_c;
   logic        cur_hit_c;
   text_attr_t  attr;
   side_t       s1, s2, s3, s4;
   logic [3:0]  fg3, bg3, fg4, bg4;
   logic [11:0] pix_c;

   assign col       = dot_counter[9:3];
   assign row       = scanline_counter[9:4];
   assign in_text_c = scanline_counter < 10'(ROWS * CHAR_H);
   assign attr      = text_data;

`ifdef CURSOR_BLINK_EN
   logic blink_phase;

   text_blink_timer #(.BLINK_FR(BLINK_FR)) u_blink (
      .clk              (clk),
      .rst              (rst),
      .active           (active),
      .dot_counter      (dot_counter),
      .scanline_counter (scanline_counter),
      .blink_phase      (blink_phase)
   );

   assign cur_hit_c = blink_phase
                    && (col == cursor_col)
                    && (row == cursor_row)
                    && (scanline_counter[3:0] >= 4'd14);
`else
   logic unused_cursor;
   assign unused_cursor = ^{cursor_col, cursor_row, BLINK_FR[0]};
   assign cur_hit_c     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         s1          <= '0;
         s2          <= '0;
         s3          <= '0;
         s4          <= '0;
         fg3         <= '0;
         bg3         <= '0;
         fg4         <= '0;
         bg4         <= '0;
         text_rd_en  <= 1'b0;
         text_addr   <= '0;
         font_rd_en  <= 1'b0;
         font_addr   <= '0;
         pixel_rgb   <= '0;
         pixel_valid <= 1'b0;
      end else begin
         s1 <= '{active: active, in_text: in_text_c, dot: dot_counter[2:0],
                 gline: scanline_counter[3:0], cur_hit: cur_hit_c};
         text_rd_en <= active & in_text_c;
         text_addr  <= 12'(row) * 12'(COLS) + 12'(col);

         s2 <= s1;

         // text_data belongs to the slot now in s2.
         s3         <= s2;
         fg3        <= attr.fg;
         bg3        <= attr.bg;
         font_rd_en <= s2.active & s2.in_text;
         font_addr  <= {attr.chr, s2.gline};

         s4  <= s3;
         fg4 <= fg3;
         bg4 <= bg3;

         // font_data belongs to the slot now in s4.
         pixel_rgb   <= pix_c;
         pixel_valid <= s4.active;
      end
   end

   // ~dot picks bit 7-dot, so dot 0 maps to the leftmost glyph bit.
   always_comb begin
      pix_c = '0;
      if (s4.active && s4.in_text) begin
         if (s4.cur_hit || font_data[~s4.dot])
            pix_c = PALETTE[fg4];
         else
            pix_c = PALETTE[bg4];
      end
   end

endmodule

// File: tb/tb_text_pixel_renderer.sv
module tb_text_pixel_renderer;
   import text_pkg::*;

   localparam int BFR = 2;

   localparam logic [11:0] PAL [16] = '{
      12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
      12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
   };

   typedef struct {
      logic        en_text;
      logic [11:0] taddr;
      logic        en_font;
      logic [11:0] faddr;
      logic        valid;
      logic [11:0] rgb;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        active = 1'b0;
   logic [9:0]  dot_counter = '0;
   logic [9:0]  scanline_counter = '0;
   logic [6:0]  cursor_col = 7'd3;
   logic [5:0]  cursor_row = 6'd1;
   logic        text_rd_en;
   logic [11:0] text_addr;
   logic [15:0] text_data = '0;
   logic        font_rd_en;
   logic [11:0] font_addr;
   logic [7:0]  font_data = '0;
   logic [11:0] pixel_rgb;
   logic        pixel_valid;

   int   n_pass = 0;
   int   n_total = 0;
   exp_t q[$];
   logic mphase = 1'b0;
   int   mcnt = 0;

   text_pixel_renderer #(.BLINK_FR(BFR)) dut (
      .clk              (clk),
      .rst              (rst),
      .active           (active),
      .dot_counter      (dot_counter),
      .scanline_counter (scanline_counter),
      .cursor_col       (cursor_col),
      .cursor_row       (cursor_row),
      .text_rd_en       (text_rd_en),
      .text_addr        (text_addr),
      .text_data        (text_data),
      .font_rd_en       (font_rd_en),
      .font_addr        (font_addr),
      .font_data        (font_data),
      .pixel_rgb        (pixel_rgb),
      .pixel_valid      (pixel_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] text_fn(input logic [11:0] a);
      if (a == 12'd202) return 16'h1F41;
      if (a == 12'd103) return 16'h2700;
      return {a[2:0], 1'b0, a[6:3], a[7:0] ^ 8'h5A};
   endfunction

   function automatic logic [7:0] font_fn(input logic [11:0] fa);
      if (fa[11:4] == 8'h00) return 8'h00;
      if (fa == 12'h411) return 8'h40;
      return fa[7:0] ^ {fa[11:8], fa[11:8]} ^ 8'hC3;
   endfunction

   // Synchronous RAM / ROM models: data one cycle after the read strobe.
   always @(posedge clk) begin
      if (text_rd_en) text_data <= text_fn(text_addr);
      if (font_rd_en) font_data <= font_fn(font_addr);
   end

   function automatic exp_t model(input logic a, input int d, input int s);
      exp_t e;
      int col, row, gl;
      logic in_t, hit;
      logic [15:0] td;
      logic [7:0] fd;
      col  = d / 8;
      row  = s / 16;
      gl   = s % 16;
      in_t = (s < 592);
      e.en_text = a && in_t;
      e.taddr   = 12'(row * 100 + col);
      td        = text_fn(e.taddr);
      e.en_font = e.en_text;
      e.faddr   = {td[7:0], 4'(gl)};
      fd        = font_fn(e.faddr);
      e.valid   = a;
      e.rgb     = 12'h000;
      hit       = 1'b0;
`ifdef CURSOR_BLINK_EN
      hit = mphase && (col == int'(cursor_col)) && (row == int'(cursor_row)) && (gl >= 14);
`endif
      if (a && in_t)
         e.rgb = (hit || fd[7 - (d % 8)]) ? PAL[td[11:8]] : PAL[td[15:12]];
      return e;
   endfunction

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
   endtask

   // One pipeline slot: check what the DUT shows now, then drive the next slot.
   task automatic step(input logic r, input logic a, input int d, input int s);
      exp_t e;
      exp_t bub;
      @(posedge clk);
      #1;
      if (q.size() >= 1) begin
         chk("text_rd_en", 12'(text_rd_en), 12'(q[$].en_text));
         if (q[$].en_text) chk("text_addr", text_addr, q[$].taddr);
      end
      if (q.size() >= 3) begin
         chk("font_rd_en", 12'(font_rd_en), 12'(q[q.size()-3].en_font));
         if (q[q.size()-3].en_font) chk("font_addr", font_addr, q[q.size()-3].faddr);
      end
      if (q.size() == 5) begin
         e = q.pop_front();
         chk("pixel_valid", 12'(pixel_valid), 12'(e.valid));
         chk("pixel_rgb", pixel_rgb, e.rgb);
      end
      rst              = r;
      active           = a;
      dot_counter      = 10'(d);
      scanline_counter = 10'(s);
      if (r) begin
         bub = '{1'b0, 12'h0, 1'b0, 12'h0, 1'b0, 12'h0};
         q.delete();
         repeat (5) q.push_back(bub);
         mphase = 1'b0;
         mcnt   = 0;
      end else begin
         q.push_back(model(a, d, s));
         if (a && d == 799 && s == 599) begin
            if (mcnt == BFR - 1) begin
               mcnt   = 0;
               mphase = ~mphase;
            end else begin
               mcnt++;
            end
         end
      end
   endtask

   initial begin
      // Reset held 3 cycles with active high.
      repeat (3) step(1'b1, 1'b1, 0, 0);
      step(1'b0, 1'b1, 17, 33);
      chk("rst_text_rd_en", 12'(text_rd_en), 12'h0);
      chk("rst_text_addr", text_addr, 12'h0);
      chk("rst_font_rd_en", 12'(font_rd_en), 12'h0);
      chk("rst_font_addr", font_addr, 12'h0);
      chk("rst_pixel_valid", 12'(pixel_valid), 12'h0);
      chk("rst_pixel_rgb", pixel_rgb, 12'h0);

      // Directed pixel: addr 202, font 0x411, glyph bit set -> white.
      step(1'b0, 1'b1, 18, 33);
      step(1'b0, 1'b1, 23, 33);
      step(1'b0, 1'b1, 24, 33);

      // End of line into wrap to dot 0.
      for (int d = 792; d < 800; d++) step(1'b0, 1'b1, d, 100);
      for (int d = 0; d < 6; d++) step(1'b0, 1'b1, d, 101);

      // Below the text grid.
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 300 + i, 595);
      step(1'b0, 1'b1, 799, 591);
      step(1'b0, 1'b1, 0, 592);

      // Active low for 4 slots mid-line.
      for (int i = 0; i < 12; i++)
         step(1'b0, (i < 4 || i > 7), 200 + i, 50);

      // One-cycle reset mid-line flushes in-flight slots.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 400 + i, 70);
      step(1'b1, 1'b1, 403, 70);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 404 + i, 70);

      // Scattered positions.
      for (int i = 0; i < 40; i++)
         step(1'b0, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 799), $urandom_range(0, 599));

      // Cursor cell (3,1) lines 14..15 across four frame ends.
      for (int f = 0; f < 4; f++) begin
         for (int d = 24; d < 32; d += 3) begin
            step(1'b0, 1'b1, d, 30);
            step(1'b0, 1'b1, d, 31);
         end
         step(1'b0, 1'b1, 25, 29);
         step(1'b0, 1'b1, 799, 599);
      end

      repeat (5) step(1'b0, 1'b0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
